// File: rtl/insn_decode_stage.sv
// insn_decode_stage: registered valid/ready instruction decoder with a 2-entry skid buffer.
// Optional macro INSN_DECODE_PC_TRACK_EN carries a PC sideband with every instruction.
`ifndef ISA_INSN_COUNT
`define ISA_ADD        0
`define ISA_ADDI       1
`define ISA_SH         2
`define ISA_SHI        3
`define ISA_NOT        4
`define ISA_AND        5
`define ISA_OR         6
`define ISA_XOR        7
`define ISA_CPY        8
`define ISA_CPYPC      9
`define ISA_LB         10
`define ISA_SB         11
`define ISA_JMPADR     12
`define ISA_JMPI       13
`define ISA_BLT        14
`define ISA_BGT        15
`define ISA_BEQ        16
`define ISA_BNEQ       17
`define ISA_INSN_COUNT 18
`endif

module insn_decode_stage #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    parameter int PC_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_insn,
`ifdef INSN_DECODE_PC_TRACK_EN
    input  logic [PC_W-1:0]            in_pc,
    output logic [PC_W-1:0]            out_pc,
`endif
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`ISA_INSN_COUNT-1:0] insn_en,
    output logic [2:0]                 reg_out,
    output logic [3:0]                 imm_out,
    output logic [DATA_W-1:0]          imm_sext,
    output logic                       is_ctrl,
    output logic [CNT_W-1:0]           decode_count
);

    typedef struct packed {
        logic [`ISA_INSN_COUNT-1:0] en;
        logic [2:0]                 rg;
        logic [3:0]                 imm;
        logic [DATA_W-1:0]          sext;
        logic                       ctrl;
`ifdef INSN_DECODE_PC_TRACK_EN
        logic [PC_W-1:0]            pc;
`endif
    } entry_t;

    function automatic entry_t decode_insn(input logic [7:0] insn);
        entry_t e;
        e = '0;
        case (insn[7:4])
            4'h0: e.en[`ISA_ADD]    = 1'b1;
            4'h1: e.en[`ISA_ADDI]   = 1'b1;
            4'h2: e.en[`ISA_SH]     = 1'b1;
            4'h3: e.en[`ISA_SHI]    = 1'b1;
            4'h4: e.en[`ISA_NOT]    = 1'b1;
            4'h5: e.en[`ISA_AND]    = 1'b1;
            4'h6: e.en[`ISA_OR]     = 1'b1;
            4'h7: e.en[`ISA_XOR]    = 1'b1;
            4'h8: begin
                if (insn[3]) e.en[`ISA_CPYPC] = 1'b1;
                else         e.en[`ISA_CPY]   = 1'b1;
            end
            4'h9: e.en[`ISA_LB]     = 1'b1;
            4'hA: e.en[`ISA_SB]     = 1'b1;
            4'hB: e.en[`ISA_JMPADR] = 1'b1;
            4'hC: e.en[`ISA_JMPI]   = 1'b1;
            4'hD: e.en[`ISA_BLT]    = 1'b1;
            4'hE: e.en[`ISA_BGT]    = 1'b1;
            4'hF: begin
                if (insn[3]) e.en[`ISA_BNEQ] = 1'b1;
                else         e.en[`ISA_BEQ]  = 1'b1;
            end
            default: e.en = '0;
        endcase
        e.rg   = insn[2:0];
        e.imm  = insn[3:0];
        e.sext = {{(DATA_W-4){insn[3]}}, insn[3:0]};
        e.ctrl = e.en[`ISA_JMPADR] | e.en[`ISA_JMPI] | e.en[`ISA_BLT] |
                 e.en[`ISA_BGT]    | e.en[`ISA_BEQ]  | e.en[`ISA_BNEQ];
        return e;
    endfunction

    entry_t            main_r;
    entry_t            skid_r;
    logic              main_valid_r;
    logic              skid_valid_r;
    logic [CNT_W-1:0]  count_r;
    entry_t            in_entry_s;
    logic              accept_s;
    logic              out_hs_s;

    assign in_ready  = !rst && !skid_valid_r;
    assign accept_s  = in_valid && in_ready;
    assign out_hs_s  = main_valid_r && out_ready;

    // Decode the incoming byte (and attach its PC when tracked).
    always_comb begin
        in_entry_s = decode_insn(in_insn);
`ifdef INSN_DECODE_PC_TRACK_EN
        in_entry_s.pc = in_pc;
`endif
    end

    // Main/skid buffer occupancy, data movement and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            count_r      <= '0;
        end else begin
            if (out_hs_s) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                main_valid_r <= 1'b0;
                skid_valid_r <= 1'b0;
            end else if (!main_valid_r || out_hs_s) begin
                // Skid can only be full while main is full, so it drains first.
                if (skid_valid_r) begin
                    main_r       <= skid_r;
                    main_valid_r <= 1'b1;
                    skid_valid_r <= 1'b0;
                end else if (accept_s) begin
                    main_r       <= in_entry_s;
                    main_valid_r <= 1'b1;
                end else begin
                    main_valid_r <= 1'b0;
                end
            end else if (accept_s) begin
                skid_r       <= in_entry_s;
                skid_valid_r <= 1'b1;
            end
        end
    end

    assign out_valid    = main_valid_r;
    assign insn_en      = main_r.en;
    assign reg_out      = main_r.rg;
    assign imm_out      = main_r.imm;
    assign imm_sext     = main_r.sext;
    assign is_ctrl      = main_r.ctrl;
    assign decode_count = count_r;
`ifdef INSN_DECODE_PC_TRACK_EN
    assign out_pc       = main_r.pc;
`endif

endmodule

// File: tb/tb_insn_decode_stage.sv
// Directed, scoreboard-based bench for insn_decode_stage (4-bit counter to exercise wrap).
`ifndef ISA_INSN_COUNT
`define ISA_ADD        0
`define ISA_ADDI       1
`define ISA_SH         2
`define ISA_SHI        3
`define ISA_NOT        4
`define ISA_AND        5
`define ISA_OR         6
`define ISA_XOR        7
`define ISA_CPY        8
`define ISA_CPYPC      9
`define ISA_LB         10
`define ISA_SB         11
`define ISA_JMPADR     12
`define ISA_JMPI       13
`define ISA_BLT        14
`define ISA_BGT        15
`define ISA_BEQ        16
`define ISA_BNEQ       17
`define ISA_INSN_COUNT 18
`endif

module tb_insn_decode_stage;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int PC_W   = 8;
    localparam int N      = `ISA_INSN_COUNT;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, flush, out_valid, out_ready, is_ctrl;
    logic [7:0]        in_insn;
    logic [N-1:0]      insn_en;
    logic [2:0]        reg_out;
    logic [3:0]        imm_out;
    logic [DATA_W-1:0] imm_sext;
    logic [CNT_W-1:0]  decode_count;
`ifdef INSN_DECODE_PC_TRACK_EN
    logic [PC_W-1:0]   in_pc, out_pc;
    assign in_pc = in_insn ^ 8'hA5;
`endif

    always #5 clk = ~clk;

    insn_decode_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
`ifdef INSN_DECODE_PC_TRACK_EN
        .in_pc(in_pc), .out_pc(out_pc),
`endif
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .insn_en(insn_en), .reg_out(reg_out), .imm_out(imm_out),
        .imm_sext(imm_sext), .is_ctrl(is_ctrl), .decode_count(decode_count)
    );

    typedef struct {
        logic [N-1:0] en;
        logic [2:0]   rg;
        logic [3:0]   imm;
        logic [7:0]   sext;
        logic         ctrl;
        logic [7:0]   pc;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_cnt;

    function automatic exp_t model(input logic [7:0] b);
        exp_t e;
        int   k;
        case (b[7:4])
            4'h0: k = `ISA_ADD;
            4'h1: k = `ISA_ADDI;
            4'h2: k = `ISA_SH;
            4'h3: k = `ISA_SHI;
            4'h4: k = `ISA_NOT;
            4'h5: k = `ISA_AND;
            4'h6: k = `ISA_OR;
            4'h7: k = `ISA_XOR;
            4'h8: k = b[3] ? `ISA_CPYPC : `ISA_CPY;
            4'h9: k = `ISA_LB;
            4'hA: k = `ISA_SB;
            4'hB: k = `ISA_JMPADR;
            4'hC: k = `ISA_JMPI;
            4'hD: k = `ISA_BLT;
            4'hE: k = `ISA_BGT;
            default: k = b[3] ? `ISA_BNEQ : `ISA_BEQ;
        endcase
        e.en    = '0;
        e.en[k] = 1'b1;
        e.rg    = b[2:0];
        e.imm   = b[3:0];
        e.sext  = b[3] ? {4'hF, b[3:0]} : {4'h0, b[3:0]};
        e.ctrl  = (k == `ISA_JMPADR) || (k == `ISA_JMPI) || (k == `ISA_BLT) ||
                  (k == `ISA_BGT) || (k == `ISA_BEQ) || (k == `ISA_BNEQ);
        e.pc    = b ^ 8'hA5;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero();
        chk("rst_insn_en", insn_en, 0);
        chk("rst_reg_out", reg_out, 0);
        chk("rst_imm_out", imm_out, 0);
        chk("rst_imm_sext", imm_sext, 0);
        chk("rst_is_ctrl", is_ctrl, 0);
        chk("rst_count", decode_count, 0);
`ifdef INSN_DECODE_PC_TRACK_EN
        chk("rst_out_pc", out_pc, 0);
`endif
    endtask

    // One clock: check outputs at the falling edge, update the scoreboard, step past the rising edge.
    task automatic cycle();
        bit   acc, hs;
        exp_t e;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, (!rst && q.size() < 2));
        chk("decode_count", decode_count, exp_cnt);
        acc = in_valid && !rst && (q.size() < 2);
        hs  = !rst && (q.size() > 0) && out_ready;
        if (hs) begin
            e = q.pop_front();
            chk("insn_en", insn_en, e.en);
            chk("reg_out", reg_out, e.rg);
            chk("imm_out", imm_out, e.imm);
            chk("imm_sext", imm_sext, e.sext);
            chk("is_ctrl", is_ctrl, e.ctrl);
`ifdef INSN_DECODE_PC_TRACK_EN
            chk("out_pc", out_pc, e.pc);
`endif
        end
        if (rst) begin
            q.delete();
            exp_cnt = '0;
        end else begin
            if (hs) exp_cnt++;
            if (flush) q.delete();
            else if (acc) q.push_back(model(in_insn));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_insn = 8'h00; flush = 1'b0; out_ready = 1'b0;
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("in_ready_in_rst", in_ready, 0);
        chk("out_valid_rst", out_valid, 0);
        chk_zero();
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // ADDI with sign-positive immediate
        out_ready = 1'b1; in_valid = 1'b1; in_insn = 8'h13;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // CPY / CPYPC / BEQ / BNEQ back to back
        in_valid = 1'b1;
        in_insn = 8'h80; cycle();
        in_insn = 8'h88; cycle();
        in_insn = 8'hF0; cycle();
        in_insn = 8'hF8; cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // Back-pressure: two accepted, third refused, drained in order
        out_ready = 1'b0; in_valid = 1'b1;
        in_insn = 8'h51; cycle();
        in_insn = 8'h62; cycle();
        in_insn = 8'h73; cycle();
        out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // Negative immediate sign-extension
        in_valid = 1'b1; in_insn = 8'h1C; cycle();
        in_valid = 1'b0; cycle(); cycle();

        // Flush with both entries full and ADD offered
        out_ready = 1'b0; in_valid = 1'b1;
        in_insn = 8'h21; cycle();
        in_insn = 8'h32; cycle();
        in_insn = 8'h00; flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1; cycle();

        // Flush while handshaking and accepting: handshake counts, input dropped
        in_valid = 1'b1; in_insn = 8'h45; cycle();
        in_insn = 8'h00; flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle(); cycle();

        // Reset with both entries full
        out_ready = 1'b0; in_valid = 1'b1;
        in_insn = 8'h9D; cycle();
        in_insn = 8'hBF; cycle();
        in_insn = 8'hC7; rst = 1'b1; cycle();
        chk("rst_full_out_valid", out_valid, 0);
        chk_zero();
        cycle();
        rst = 1'b0; in_valid = 1'b0; cycle();

        // 17 handshakes on a 4-bit counter wrap to 1
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_insn = 8'(i * 13 + 7);
            cycle();
        end
        in_valid = 1'b0;
        cycle(); cycle();
        chk("count_wrap", decode_count, 1);

        // Every instruction byte, full throughput
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_insn = i[7:0];
            cycle();
        end
        in_valid = 1'b0;
        cycle(); cycle();
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/insn_decode_stage.md
Name: insn_decode_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage for the 8-bit softcore. It replaces the purely combinational decoder.
- Accepts one fetched 8-bit instruction per cycle on a valid/ready interface and decodes it into a one-hot instruction-enable vector, register field and immediate fields.
- Presents the decoded result to execute through a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.
- Supports pipeline flush on taken branches/jumps and keeps a decoded-instruction counter.

Parameters:
- DATA_W, 8, datapath width; width of the sign-extended immediate output.
- CNT_W, 16, width of the decoded-instruction counter.
- PC_W, 8, width of the PC sideband (used only with the optional feature).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_insn  input  8  instruction byte.
- flush  input  1  discard all held instructions (taken branch/jump).
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  execute accepts the decoded instruction.
- insn_en  output  `ISA_INSN_COUNT  one-hot enable, bit positions per `ISA_* indices.
- reg_out  output  3  insn[2:0].
- imm_out  output  4  insn[3:0], raw.
- imm_sext  output  DATA_W  insn[3:0] sign-extended to DATA_W.
- is_ctrl  output  1  decoded insn is JMPADR/JMPI/BLT/BGT/BEQ/BNEQ.
- decode_count  output  CNT_W  number of output handshakes since reset.

Behaviour:
- Decode (combinational on the input side, registered into the buffer): opcode = insn[7:4], util = insn[3].
  - 0x0 ADD, 0x1 ADDI, 0x2 SH, 0x3 SHI, 0x4 NOT, 0x5 AND, 0x6 OR, 0x7 XOR.
  - 0x8: CPYPC if util=1, else CPY.
  - 0x9 LB, 0xA SB, 0xB JMPADR, 0xC JMPI, 0xD BLT, 0xE BGT.
  - 0xF: BNEQ if util=1, else BEQ.
  - Exactly one insn_en bit is set for every input byte.
- Storage: two entries, "main" (drives outputs) and "skid". Each entry holds valid + decoded fields (+ PC with the feature).
- Handshakes:
  - in_ready = !rst && !skid_valid.
  - Input accept: in_valid && in_ready.
  - Output handshake: out_valid && out_ready.
  - out_valid = main_valid.
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1. Sustained throughput is 1/cycle while out_ready=1.
- Update rules per edge (flush=0):
  - Main empty or handshaking, skid empty: accepted input goes to main; with no accept, main_valid clears.
  - Main full and not handshaking, accept: input goes to skid (in_ready drops next cycle).
  - Main handshaking, skid full: skid moves to main and skid clears. A new accept cannot occur because in_ready=0.
  - Order is strictly preserved.
- Outputs while out_valid=0: insn_en, reg_out, imm_out, imm_sext, is_ctrl hold their last values (don't-care to consumers). After reset they are all 0.
- flush=1:
  - Both valids clear next edge.
  - An input accepted in the same cycle is discarded.
  - A simultaneous output handshake still counts (decode_count increments).
- decode_count: +1 per output handshake, wraps from 2^CNT_W-1 to 0.
- Reset (sync, rst=1 at edge):
  - main_valid=0, skid_valid=0, all decoded output registers 0, decode_count=0, out_valid=0.
  - in_ready=0 while rst is high and 1 in the first cycle after.
  - Reset mid-transfer drops held instructions; no handshake is counted in the reset cycle.

Optional Feature:
- Macro: INSN_DECODE_PC_TRACK_EN.
- Defined: adds ports in_pc (input, PC_W) and out_pc (output, PC_W, reset 0). The PC is captured with its instruction and travels through main/skid identically, so out_pc always matches the displayed instruction.
- Undefined: ports absent, no PC storage; all other behaviour identical.

Test Plan:
- Reset then in_insn=0x13 valid, out_ready=1 -> next cycle out_valid=1, insn_en=ADDI only, reg_out=3, imm_out=0x3, imm_sext=0x03, is_ctrl=0; decode_count=1 after handshake.
- Stream 0x80, 0x88, 0xF0, 0xF8 back-to-back, out_ready=1 -> CPY, CPYPC, BEQ, BNEQ on consecutive cycles; is_ctrl=0,0,1,1; decode_count=4.
- Hold out_ready=0, offer 0x51, 0x62, 0x73 -> first two accepted, in_ready=0 on third; raise out_ready -> AND, OR, XOR emitted in order, none lost or duplicated.
- in_insn=0x1C -> imm_out=0xC, imm_sext=0xFC (DATA_W=8).
- Two entries held, assert flush with in_valid=1 (0x00) -> out_valid=0 next cycle; ADD not emitted; in_ready=1 again.
- CNT_W=4, 17 handshakes -> decode_count=1 (wrap). Assert rst with both entries full -> all outputs 0, out_valid=0, in_ready=0 during reset.
